// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ADDR_W      = 8;
    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;
    localparam int DEPTH_WORDS = 64;

    localparam logic [WORD_W-1:0] NOP = 32'h00000013;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian stream bytes into one instruction word.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              complete
);

    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] asm_q;

    // word is the register with the incoming byte already dropped into its lane,
    // so the top can capture the finished word on the same edge as the 4th byte.
    always_comb begin
        word = asm_q;
        word[{byte_idx, 3'b000} +: 8] = byte_data;
        complete = accept && (byte_idx == 2'(INSTR_BYTES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q    <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (accept) begin
            asm_q    <= word;
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit words and writes them to instruction memory from 0x00,
// holding the fetch path until a complete program has been written.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [1:0]        dbg_state
);

    state_t            state_q, state_d;
    logic [5:0]        word_idx;
    logic [6:0]        count_q;
    logic              err_q;
    logic              hold_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;

    logic              accept;
    logic              can_start;
    logic              count_ok;
    logic              start_ok;
    logic              start_bad;
    logic              last_word;
    logic              asm_clear;
    logic              word_complete;
    logic [WORD_W-1:0] asm_word;

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready
    // are both 1; the source keeps byte_data stable while byte_ready is 0.
    assign accept    = byte_valid && (state_q == RECV);
    assign can_start = (state_q == IDLE) || (state_q == DONE);
    assign count_ok  = (word_count != 7'd0) && (word_count <= 7'(DEPTH_WORDS));
    assign start_ok  = can_start && start && count_ok;
    assign start_bad = can_start && start && !count_ok;
    assign last_word = ({1'b0, word_idx} == (count_q - 7'd1));
    assign asm_clear = start_ok || ((state_q == WRITE) && !last_word);

    imem_loader_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (asm_word),
        .complete  (word_complete)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_bad)     state_d = IDLE;
                else if (start_ok) state_d = RECV;
            end
            RECV:    if (word_complete) state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : RECV;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_idx <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                count_q  <= word_count;
                word_idx <= '0;
                err_q    <= 1'b0;
                hold_q   <= 1'b1;
            end
            if (start_bad) err_q <= 1'b1;
            // Address and data are captured with the 4th byte and then held.
            if (word_complete) begin
                addr_q  <= {word_idx, 2'b00};
                wdata_q <= asm_word;
            end
            if (state_q == WRITE) begin
                if (last_word) hold_q <= 1'b0;
                else           word_idx <= word_idx + 6'd1;
            end
        end
    end

    assign byte_ready = (state_q == RECV);
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q == RECV) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign cpu_hold   = hold_q;
    assign dbg_state  = state_q;

endmodule
